// File: rtl/mem_feed_control.sv
// mem_feed_control: per-lane address/enable generator streaming a num_row x num_col tile,
// either in lockstep or as a one-cycle-per-lane diagonal wavefront.
module mem_feed_control #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      active,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [DIM_W-1:0]          num_row,
    input  logic [DIM_W-1:0]          num_col,
    input  logic                      skew_en,
    input  logic                      reverse,
    output logic [LANES*ADDR_W-1:0]   out_addr,
    output logic [LANES-1:0]          out_en,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [DIM_W:0] ONE = (DIM_W+1)'(1);
    state_t state;
    logic [ADDR_W-1:0] base_q, stride_q, base_s, stride_s;
    logic [DIM_W-1:0] nrow_q, ncol_q, ncol_in, nrow_s, ncol_s;
    logic skew_q, rev_q, skew_s, rev_s, sel, zero_dim;
    logic [DIM_W:0] t_q, step, last;
    logic [LANES*ADDR_W-1:0] nxt_addr;
    logic [LANES-1:0] nxt_en;
    // Outside RUN the next outputs are step 0 of a run built from the live inputs,
    // so step-0 values appear on the same edge that accepts the start.
    assign sel      = state != RUN;
    assign ncol_in  = (num_col > DIM_W'(LANES)) ? DIM_W'(LANES) : num_col;
    assign zero_dim = num_row == '0 || ncol_in == '0;
    assign base_s   = sel ? base_addr : base_q;
    assign stride_s = sel ? stride : stride_q;
    assign nrow_s   = sel ? num_row : nrow_q;
    assign ncol_s   = sel ? ncol_in : ncol_q;
    assign skew_s   = sel ? skew_en : skew_q;
    assign rev_s    = sel ? reverse : rev_q;
    assign step     = sel ? '0 : t_q + ONE;
    assign last     = skew_s ? {1'b0, nrow_s} + {1'b0, ncol_s} - ONE : {1'b0, nrow_s};
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [DIM_W:0] LI = (DIM_W+1)'(i);
        logic [DIM_W:0] off, k, r;
        assign off = skew_s ? LI : '0;
        assign k   = step - off;
        assign r   = rev_s ? {1'b0, nrow_s} - ONE - k : k;
        assign nxt_en[i] = LI < {1'b0, ncol_s} && step >= off && k < {1'b0, nrow_s};
        assign nxt_addr[i*ADDR_W +: ADDR_W] = nxt_en[i] ? base_s + ADDR_W'(r) * stride_s : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            t_q      <= '0;
            base_q   <= '0;
            stride_q <= '0;
            nrow_q   <= '0;
            ncol_q   <= '0;
            skew_q   <= 1'b0;
            rev_q    <= 1'b0;
            out_addr <= '0;
            out_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (sel) begin
            if (active) begin
                base_q   <= base_addr;
                stride_q <= stride;
                nrow_q   <= num_row;
                ncol_q   <= ncol_in;
                skew_q   <= skew_en;
                rev_q    <= reverse;
                t_q      <= '0;
                state    <= zero_dim ? FIN : RUN;
                out_addr <= zero_dim ? '0 : nxt_addr;
                out_en   <= zero_dim ? '0 : nxt_en;
                busy     <= !zero_dim;
                done     <= zero_dim;
            end else begin
                state    <= IDLE;
                out_addr <= '0;
                out_en   <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end
        end else if (step == last) begin
            state    <= FIN;
            out_addr <= '0;
            out_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
        end else begin
            t_q      <= step;
            out_addr <= nxt_addr;
            out_en   <= nxt_en;
        end
    end
endmodule

// File: tb/tb_mem_feed_control.sv
// tb_mem_feed_control: directed checks of mem_feed_control (16 lanes, 8-bit addresses).
module tb_mem_feed_control;
    logic clk = 0, reset = 1, active = 0, skew_en = 0, reverse = 0;
    logic [7:0] base_addr = 0, stride = 0;
    logic [4:0] num_row = 0, num_col = 0;
    logic [127:0] out_addr;
    logic [15:0] out_en;
    logic busy, done;
    int total = 0, bad = 0;
    logic [15:0] en_tr [16];
    logic [127:0] addr_tr [16];
    logic busy_tr [16], done_tr [16];
    logic [7:0] flat_tab [4] = '{8'hF8, 8'h08, 8'h18, 8'h28};
    logic [7:0] rl0_tab [6] = '{8'h24, 8'h22, 8'h20, 8'h00, 8'h00, 8'h00};
    logic [7:0] rl1_tab [6] = '{8'h00, 8'h24, 8'h22, 8'h20, 8'h00, 8'h00};
    logic [15:0] ren_tab [6] = '{16'h1, 16'h3, 16'h3, 16'h2, 16'h0, 16'h0};
    logic [1:0] hold_tab [8] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

    mem_feed_control #(.LANES(16), .ADDR_W(8), .DIM_W(5)) dut (
        .clk(clk), .reset(reset), .active(active), .base_addr(base_addr), .stride(stride),
        .num_row(num_row), .num_col(num_col), .skew_en(skew_en), .reverse(reverse),
        .out_addr(out_addr), .out_en(out_en), .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane(input int t, input int i);
        return addr_tr[t][i*8 +: 8];
    endfunction

    task automatic go(input logic [7:0] b, input logic [7:0] s, input logic [4:0] r,
                      input logic [4:0] c, input logic sk, input logic rv, input logic hold);
        @(negedge clk);
        base_addr = b; stride = s; num_row = r; num_col = c; skew_en = sk; reverse = rv;
        active = 1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) active = 0;
    endtask

    // Samples at each falling edge starting with step 0; optionally pokes active mid-run.
    task automatic capture(input int n, input int inj_t, input logic [7:0] inj_base);
        for (int t = 0; t < n; t++) begin
            en_tr[t] = out_en; addr_tr[t] = out_addr; busy_tr[t] = busy; done_tr[t] = done;
            if (t == inj_t) begin active = 1; base_addr = inj_base; end
            if (t == inj_t + 1) active = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        logic [8:0] acc;
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst_en", out_en, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_busy_done", {busy, done}, 0);
        reset = 0;

        go(8'h00, 8'h01, 5'd3, 5'd7, 1, 0, 0);
        capture(12, -10, 0);
        nb = 0; acc = 0;
        for (int t = 0; t < 12; t++) begin
            nb += int'(busy_tr[t]);
            acc |= en_tr[t][15:7];
            chk("t1_l0_en", en_tr[t][0], t < 3);
            chk("t1_l0_addr", lane(t, 0), t < 3 ? t : 0);
            chk("t1_l6_en", en_tr[t][6], t >= 6 && t <= 8);
            chk("t1_l6_addr", lane(t, 6), (t >= 6 && t <= 8) ? t - 6 : 0);
            chk("t1_done", done_tr[t], t == 9);
        end
        chk("t1_busy_len", nb, 9);
        chk("t1_hi_lanes", acc, 0);

        go(8'hF8, 8'h10, 5'd4, 5'd16, 0, 0, 0);
        capture(6, -10, 0);
        for (int t = 0; t < 6; t++) begin
            chk("t2_en", en_tr[t], t < 4 ? 16'hFFFF : 16'h0);
            chk("t2_l0_addr", lane(t, 0), t < 4 ? flat_tab[t] : 8'h0);
            chk("t2_l15_addr", lane(t, 15), t < 4 ? flat_tab[t] : 8'h0);
            chk("t2_done", done_tr[t], t == 4);
        end

        go(8'h20, 8'h02, 5'd3, 5'd2, 1, 1, 0);
        capture(6, -10, 0);
        for (int t = 0; t < 6; t++) begin
            chk("t3_en", en_tr[t], ren_tab[t]);
            chk("t3_l0_addr", lane(t, 0), rl0_tab[t]);
            chk("t3_l1_addr", lane(t, 1), rl1_tab[t]);
            chk("t3_done", done_tr[t], t == 4);
        end

        go(8'h33, 8'h01, 5'd0, 5'd5, 1, 0, 0);
        capture(3, -10, 0);
        for (int t = 0; t < 3; t++) begin
            chk("t4_done", done_tr[t], t == 0);
            chk("t4_busy", busy_tr[t], 0);
            chk("t4_en", en_tr[t], 0);
        end

        go(8'h00, 8'h01, 5'd3, 5'd7, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("t5_pre_en", out_en, 16'h0007);
        #2 reset = 1;
        #1;
        chk("t5_async_en", out_en, 0);
        chk("t5_async_addr", out_addr, 0);
        chk("t5_async_busy_done", {busy, done}, 0);
        @(negedge clk);
        reset = 0;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            seen |= done | busy;
            @(negedge clk);
        end
        chk("t5_no_done", seen, 0);
        go(8'h00, 8'h01, 5'd3, 5'd7, 1, 0, 0);
        capture(12, -10, 0);
        nb = 0;
        for (int t = 0; t < 12; t++) begin
            nb += int'(busy_tr[t]);
            chk("t5_rerun_done", done_tr[t], t == 9);
        end
        chk("t5_rerun_busy_len", nb, 9);
        chk("t5_rerun_l6_last", lane(8, 6), 8'h02);

        go(8'h40, 8'h01, 5'd3, 5'd7, 1, 0, 0);
        capture(12, 1, 8'h80);
        nb = 0;
        for (int t = 0; t < 12; t++) begin
            nb += int'(busy_tr[t]);
            chk("t6_l0_addr", lane(t, 0), t < 3 ? 8'h40 + 8'(t) : 8'h0);
            chk("t6_done", done_tr[t], t == 9);
        end
        chk("t6_busy_len", nb, 9);
        chk("t6_l6_last", lane(8, 6), 8'h42);

        go(8'h10, 8'h01, 5'd2, 5'd1, 0, 0, 1);
        capture(8, -10, 0);
        active = 0;
        for (int t = 0; t < 8; t++) begin
            chk("t7_busy_done", {busy_tr[t], done_tr[t]}, hold_tab[t]);
            chk("t7_l0_addr", lane(t, 0), hold_tab[t][1] ? 8'h10 + 8'(t % 3) : 8'h0);
        end
        repeat (5) @(negedge clk);
        chk("t7_idle", {busy, done, out_en}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
